// File: rtl/dino_game_ctrl_if.sv
// Signal bundle between the dino game-flow controller and its neighbours.
// The controller drives the status/score side; the environment drives jump and collide.
interface dino_game_ctrl_if #(
  parameter int DIGITS = 6,
  parameter int LVLW   = 2
);
  logic                  jump;
  logic                  collide;
  logic                  running;
  logic                  game_over;
  logic [LVLW-1:0]       level;
  logic [4*DIGITS-1:0]   score_bcd;
  logic [4*DIGITS-1:0]   hiscore_bcd;
  logic [7*DIGITS-1:0]   seven;

  modport master (
    input  jump, collide,
    output running, game_over, level, score_bcd, hiscore_bcd, seven
  );

  modport slave (
    output jump, collide,
    input  running, game_over, level, score_bcd, hiscore_bcd, seven
  );
endinterface

// File: rtl/dino_game_ctrl.sv
// Game-flow controller for the dinosaur runner: IDLE/RUN/OVER sequencing,
// BCD score and high score, speed level, and blanked seven-segment score display.
module dino_game_ctrl #(
  parameter int DIGITS     = 6,
  parameter int TICK_DIV   = 1024,
  parameter int LEVEL_STEP = 50,
  parameter int MAX_LEVEL  = 3,
  parameter int LVLW       = 2
) (
  input  logic            clock,
  input  logic            rst,
  dino_game_ctrl_if.master game
);

  localparam int CW  = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int SW  = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;
  localparam int SBW = 4 * DIGITS;
  localparam int SGW = 7 * DIGITS;
  localparam logic [SGW-1:0] SEVEN_RST = ~SGW'(7'b0111111);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t          state, state_n;
  logic            s1, s2, s3;
  logic            press;
  logic            start, stop, tick, advance;
  logic [31:0]     period;
  logic [CW-1:0]   tick_cnt;
  logic [SW-1:0]   step_cnt;
  logic [LVLW-1:0] level;
  logic [SBW-1:0]  score, hiscore, score_inc;
  logic            score_max, carry;
  logic [SGW-1:0]  seven, seven_n;
  logic            nz;
  logic            running, game_over;

  // Falling edge of the (active-low) button after the synchronizer.
  assign press = s3 & ~s2;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0011000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_n = state;
    start   = 1'b0;
    stop    = 1'b0;
    unique case (state)
      IDLE: if (press) begin
        state_n = RUN;
        start   = 1'b1;
      end
      RUN: if (game.collide) begin
        state_n = OVER;
        stop    = 1'b1;
      end
      OVER: if (press) begin
        state_n = RUN;
        start   = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Points period halves per level, never below one cycle.
  always_comb begin
    period = 32'(TICK_DIV) >> level;
    if (period == 32'd0) period = 32'd1;
    tick    = (32'(tick_cnt) >= (period - 32'd1));
    advance = (state == RUN) && !game.collide && tick && !score_max;
  end

  always_comb begin
    carry     = 1'b1;
    score_max = 1'b1;
    score_inc = score;
    for (int i = 0; i < DIGITS; i++) begin
      if (score[4*i +: 4] != 4'd9) score_max = 1'b0;
      if (carry) begin
        if (score[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Leading zeros blank from the top down; digit 0 always shows.
  always_comb begin
    nz      = 1'b0;
    seven_n = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (score[4*i +: 4] != 4'd0) nz = 1'b1;
      if (nz || (i == 0)) seven_n[7*i +: 7] = seg(score[4*i +: 4]);
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clock) begin
    if (rst) begin
      s1        <= 1'b1;
      s2        <= 1'b1;
      s3        <= 1'b1;
      tick_cnt  <= '0;
      step_cnt  <= '0;
      level     <= '0;
      score     <= '0;
      hiscore   <= '0;
      seven     <= SEVEN_RST;
      running   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      s1        <= game.jump;
      s2        <= s1;
      s3        <= s2;
      running   <= (state_n == RUN);
      game_over <= (state_n == OVER);
      seven     <= seven_n;
      if (start) begin
        tick_cnt <= '0;
        step_cnt <= '0;
        level    <= '0;
        score    <= '0;
      end else if ((state == RUN) && !game.collide) begin
        if (tick) tick_cnt <= '0;
        else      tick_cnt <= tick_cnt + 1'b1;
        if (advance) begin
          score <= score_inc;
          if (step_cnt == SW'(LEVEL_STEP - 1)) begin
            step_cnt <= '0;
            if (level != LVLW'(MAX_LEVEL)) level <= level + 1'b1;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
      end
      if (stop && (score > hiscore)) hiscore <= score;
    end
  end

  assign game.running     = running;
  assign game.game_over   = game_over;
  assign game.level       = level;
  assign game.score_bcd   = score;
  assign game.hiscore_bcd = hiscore;
  assign game.seven       = seven;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Self-checking bench for dino_game_ctrl: a decimal reference model pushes expected
// outputs into a scoreboard each cycle; they are popped and compared after the edge.
module tb_dino_game_ctrl;

  localparam int DIGITS = 2;
  localparam int TDIV   = 4;
  localparam int LSTEP  = 3;
  localparam int MAXL   = 2;
  localparam int LVLW   = 2;

  logic clock = 1'b0;
  logic rst   = 1'b1;

  dino_game_ctrl_if #(.DIGITS(DIGITS), .LVLW(LVLW)) bus ();

  dino_game_ctrl #(
    .DIGITS(DIGITS), .TICK_DIV(TDIV), .LEVEL_STEP(LSTEP),
    .MAX_LEVEL(MAXL), .LVLW(LVLW)
  ) dut (
    .clock(clock),
    .rst  (rst),
    .game (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        run;
    logic        over;
    logic [1:0]  lvl;
    logic [7:0]  sc;
    logic [7:0]  hi;
    logic [13:0] sev;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: scores kept as plain integers.
  int          m_state;
  bit          m_s1, m_s2, m_s3;
  int          m_score, m_hi, m_cnt;
  logic [13:0] m_seven;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b1000000;  1: seg = 7'b1111001;  2: seg = 7'b0100100;
      3: seg = 7'b0110000;  4: seg = 7'b0011001;  5: seg = 7'b0010010;
      6: seg = 7'b0000010;  7: seg = 7'b1111000;  8: seg = 7'b0000000;
      9: seg = 7'b0011000;  default: seg = 7'b1111111;
    endcase
  endfunction

  function automatic logic [13:0] exp_seven(input int v);
    exp_seven = {((v / 10) == 0) ? 7'b1111111 : seg(v / 10), seg(v % 10)};
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int exp_level(input int v);
    exp_level = (v / LSTEP > MAXL) ? MAXL : v / LSTEP;
  endfunction

  task automatic model_edge(input bit j, input bit c, input bit r);
    bit press;
    int p;
    if (r) begin
      m_state = 0;
      m_s1 = 1; m_s2 = 1; m_s3 = 1;
      m_score = 0; m_hi = 0; m_cnt = 0;
      m_seven = 14'b1111111_1000000;
      return;
    end
    press   = m_s3 && !m_s2;
    m_seven = exp_seven(m_score);
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = j;
    case (m_state)
      1: begin
        if (c) begin
          if (m_score > m_hi) m_hi = m_score;
          m_state = 2;
        end else begin
          p = TDIV >> exp_level(m_score);
          if (p < 1) p = 1;
          if (m_cnt >= p - 1) begin
            m_cnt = 0;
            if (m_score < 99) m_score++;
          end else begin
            m_cnt++;
          end
        end
      end
      default: if (press) begin
        m_state = 1;
        m_score = 0;
        m_cnt   = 0;
      end
    endcase
  endtask

  task automatic cycle(input bit j, input bit c, input bit r);
    exp_t e;
    bus.jump    = j;
    bus.collide = c;
    rst         = r;
    model_edge(j, c, r);
    e.run  = (m_state == 1);
    e.over = (m_state == 2);
    e.lvl  = 2'(exp_level(m_score));
    e.sc   = to_bcd(m_score);
    e.hi   = to_bcd(m_hi);
    e.sev  = m_seven;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("running",   32'(bus.running),     32'(e.run));
    check("game_over", 32'(bus.game_over),   32'(e.over));
    check("level",     32'(bus.level),       32'(e.lvl));
    check("score",     32'(bus.score_bcd),   32'(e.sc));
    check("hiscore",   32'(bus.hiscore_bcd), 32'(e.hi));
    check("seven",     32'(bus.seven),       32'(e.sev));
  endtask

  // Release the button, then press and hold it; the game is in RUN afterwards.
  task automatic restart();
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    check("restart_running", 32'(bus.running), 32'd1);
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (m_score < target && guard < 1000) begin
      cycle(1'b0, 1'b0, 1'b0);
      guard++;
    end
    check("run_to", 32'(bus.score_bcd), 32'(to_bcd(target)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.jump    = 1'b1;
    bus.collide = 1'b0;

    // Reset held two cycles.
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    check("rst_score", 32'(bus.score_bcd), 32'h00);
    check("rst_seven", 32'(bus.seven), 32'(14'b1111111_1000000));
    check("rst_running", 32'(bus.running), 32'd0);
    repeat (2) cycle(1'b1, 1'b0, 1'b0);

    // Press: running two edges after first low sample, then 4 cycles per point.
    cycle(1'b0, 1'b0, 1'b0);
    check("press_k", 32'(bus.running), 32'd0);
    cycle(1'b0, 1'b0, 1'b0);
    check("press_k1", 32'(bus.running), 32'd0);
    cycle(1'b0, 1'b0, 1'b0);
    check("press_k2", 32'(bus.running), 32'd1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    check("score_01", 32'(bus.score_bcd), 32'h01);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    check("score_02", 32'(bus.score_bcd), 32'h02);

    // Level steps: level 1 at 3 (period 2), level 2 at 6.
    run_to(3);
    check("level_at_3", 32'(bus.level), 32'd1);
    cycle(1'b0, 1'b0, 1'b0);
    check("p2_hold", 32'(bus.score_bcd), 32'h03);
    cycle(1'b0, 1'b0, 1'b0);
    check("p2_step", 32'(bus.score_bcd), 32'h04);
    run_to(6);
    check("level_at_6", 32'(bus.level), 32'd2);

    // Collide on a tick edge at 07.
    run_to(7);
    cycle(1'b0, 1'b1, 1'b0);
    check("over_flag", 32'(bus.game_over), 32'd1);
    check("over_score", 32'(bus.score_bcd), 32'h07);
    check("over_hi", 32'(bus.hiscore_bcd), 32'h07);
    cycle(1'b0, 1'b1, 1'b0);
    check("over_hold", 32'(bus.score_bcd), 32'h07);

    // Lower score does not replace the high score.
    restart();
    run_to(5);
    cycle(1'b0, 1'b1, 1'b0);
    check("hi_kept", 32'(bus.hiscore_bcd), 32'h07);

    // Saturation at 99 while still running.
    restart();
    run_to(99);
    check("level_sat", 32'(bus.level), 32'd2);
    cycle(1'b0, 1'b0, 1'b0);
    check("sat_score", 32'(bus.score_bcd), 32'h99);
    check("sat_running", 32'(bus.running), 32'd1);
    check("sat_seven", 32'(bus.seven), 32'(14'b0011000_0011000));
    cycle(1'b0, 1'b1, 1'b0);
    check("hi_99", 32'(bus.hiscore_bcd), 32'h99);

    // Reset mid-game at 12 with a press and collide on the same edge.
    restart();
    run_to(8);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("pre_rst_score", 32'(bus.score_bcd), 32'h12);
    cycle(1'b0, 1'b1, 1'b1);
    check("mid_rst_running", 32'(bus.running), 32'd0);
    check("mid_rst_score", 32'(bus.score_bcd), 32'h00);
    check("mid_rst_hi", 32'(bus.hiscore_bcd), 32'h00);
    check("mid_rst_level", 32'(bus.level), 32'd0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    check("idle_after_rst", 32'(bus.running), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
